// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receive path.
//   ps2_rx_state_t  frame deserialiser states
//   PS2_PREFIX_EXT  extended-key prefix byte (E0)
//   PS2_PREFIX_BRK  break (key release) prefix byte (F0)
//   CODE_W          width of a FIFO entry; 10 when PS2_EXT_CODE_EN is
//                   defined ({ext, brk, code}), otherwise 8 (raw byte)
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

`ifdef PS2_EXT_CODE_EN
  localparam int unsigned CODE_W = 10;
`else
  localparam int unsigned CODE_W = 8;
`endif

endpackage

// File: rtl/ps2_code_fifo.sv
// ps2_code_fifo: first-word fall-through FIFO for received scan codes.
//   clk, rst   clock, asynchronous active-high reset
//   push/wdata write an entry (caller guarantees room or a same-cycle pop)
//   pop        remove the head (ignored when empty)
//   rdata      current head; reads as zero while empty
//   count      occupancy, 0..DEPTH
//   full/empty occupancy flags
module ps2_code_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  // Stale storage is masked so the head reads zero after reset.
  assign rdata  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with scan-code FIFO.
//   clk, rst          system clock, asynchronous active-high reset
//   ps2_clk/ps2_data  raw asynchronous PS/2 lines (idle high)
//   code_data         FIFO head (CODE_W bits)
//   code_valid        FIFO not empty
//   code_ready        consumer accepts the head when code_valid is high
//   fifo_count        FIFO occupancy
//   parity_err        pulse: frame dropped for bad parity
//   frame_err         pulse: bad start/stop bit or watchdog timeout
//   overflow          pulse: good code dropped, FIFO full
// Macro PS2_EXT_CODE_EN: merge E0/F0 prefixes into {ext, brk, code}.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_MHZ    = 50,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT_US = 100
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic [CODE_W-1:0]               code_data,
  output logic                            code_valid,
  input  logic                            code_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam int unsigned FCW    = $clog2(FILTER_LEN+1);
  localparam int unsigned TO_CYC = CLK_MHZ * TIMEOUT_US;
  localparam int unsigned WD_W   = $clog2(TO_CYC+1);

  logic [1:0]     clk_sync, data_sync;
  logic           clk_filt, data_filt, clk_filt_d;
  logic [FCW-1:0] clk_fcnt, data_fcnt;
  logic           strobe;

  ps2_rx_state_t  state, state_n;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par_bit;
  logic [WD_W-1:0] wd;
  logic           wd_expire;

  logic           ferr_n, perr_n, good;
  logic           clr_bits, shift_en, cap_par;

  logic              push_req, push_ok, push, pop;
  logic [CODE_W-1:0] push_word;
  logic              fifo_full, fifo_empty;

  // Input conditioning
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_filt <= 1'b1;
      clk_fcnt <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      clk_fcnt <= '0;
    end else if (clk_fcnt == FCW'(FILTER_LEN-1)) begin
      clk_filt <= clk_sync[1];
      clk_fcnt <= '0;
    end else begin
      clk_fcnt <= clk_fcnt + FCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_filt <= 1'b1;
      data_fcnt <= '0;
    end else if (data_sync[1] == data_filt) begin
      data_fcnt <= '0;
    end else if (data_fcnt == FCW'(FILTER_LEN-1)) begin
      data_filt <= data_sync[1];
      data_fcnt <= '0;
    end else begin
      data_fcnt <= data_fcnt + FCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) clk_filt_d <= 1'b1;
    else     clk_filt_d <= clk_filt;
  end

  assign strobe = clk_filt_d && !clk_filt;

  // A strobe landing on the expiry cycle still counts as in time.
  assign wd_expire = (state != IDLE) && !strobe && (wd == WD_W'(TO_CYC));

  // Frame FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    ferr_n   = 1'b0;
    perr_n   = 1'b0;
    good     = 1'b0;
    clr_bits = 1'b0;
    shift_en = 1'b0;
    cap_par  = 1'b0;
    if (wd_expire) begin
      state_n = IDLE;
      ferr_n  = 1'b1;
    end else if (strobe) begin
      case (state)
        IDLE: begin
          if (!data_filt) begin
            clr_bits = 1'b1;
            state_n  = DATA;
          end else begin
            ferr_n = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          cap_par = 1'b1;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (!data_filt)              ferr_n = 1'b1;
          else if (!(^{shreg, par_bit})) perr_n = 1'b1;
          else                         good   = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (clr_bits) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {data_filt, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (cap_par) par_bit <= data_filt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 wd <= '0;
    else if (state == IDLE || strobe || wd_expire) wd <= '0;
    else                                     wd <= wd + WD_W'(1);
  end

  // Prefix handling and push decision
`ifdef PS2_EXT_CODE_EN
  logic ext_f, brk_f, is_pfx;

  assign is_pfx    = (shreg == PS2_PREFIX_EXT) || (shreg == PS2_PREFIX_BRK);
  assign push_req  = good && !is_pfx;
  assign push_word = {ext_f, brk_f, shreg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (ferr_n || perr_n) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (good) begin
      if (shreg == PS2_PREFIX_EXT) begin
        ext_f <= 1'b1;
      end else if (shreg == PS2_PREFIX_BRK) begin
        brk_f <= 1'b1;
      end else begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
    end
  end
`else
  assign push_req  = good;
  assign push_word = shreg;
`endif

  assign pop     = code_valid && code_ready;
  assign push_ok = !fifo_full || pop;
  assign push    = push_req && push_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      overflow   <= push_req && !push_ok;
    end
  end

  ps2_code_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (code_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign code_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed self-checking bench for ps2_rx_fifo.
// Runs with a 1 MHz-equivalent timeout scale (100-cycle watchdog) so that
// frames are short; PS/2 bit period is 40 system cycles.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ps2_clk = 1'b1;
  logic              ps2_data = 1'b1;
  logic [CODE_W-1:0] code_data;
  logic              code_valid;
  logic              code_ready = 1'b0;
  logic [3:0]        fifo_count;
  logic              parity_err, frame_err, overflow;

  int errors = 0;
  int checks = 0;

  int n_perr = 0, n_ferr = 0, n_ovf = 0, n_vcyc = 0;
  logic [CODE_W-1:0] rx_q [$];

  ps2_rx_fifo #(
    .CLK_MHZ    (1),
    .FIFO_DEPTH (8),
    .FILTER_LEN (4),
    .TIMEOUT_US (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code_data  (code_data),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Counts pulse cycles (a stretched pulse counts more than once) and
  // records every popped code.
  always @(negedge clk) begin
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if (overflow)   n_ovf++;
    if (code_valid) n_vcyc++;
    if (code_valid && code_ready) rx_q.push_back(code_data);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(10);
    ps2_clk = 1'b0;
    tick(20);
    ps2_clk = 1'b1;
    tick(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stopb);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ pflip);
    send_bit(stopb);
    ps2_data = 1'b1;
    tick(20);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", code_valid); end
    checks++; if (code_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", code_data); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_single;
    int b, p0, f0, v0;
    b = rx_q.size(); p0 = n_perr; f0 = n_ferr; v0 = n_vcyc;
    code_ready = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (rx_q.size() - b !== 1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", rx_q.size() - b); end
    else begin
      checks++; if (rx_q[b] !== CODE_W'(8'h1C)) begin errors++; $display("FAIL single_data got=%h exp=1c", rx_q[b]); end
    end
    checks++; if (n_vcyc - v0 !== 1) begin errors++; $display("FAIL single_valid_cycles got=%0d exp=1", n_vcyc - v0); end
    checks++; if (n_perr - p0 !== 0) begin errors++; $display("FAIL single_perr got=%0d exp=0", n_perr - p0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL single_ferr got=%0d exp=0", n_ferr - f0); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL single_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_errors;
    int b, p0, f0;
    code_ready = 1'b1;
    b = rx_q.size(); p0 = n_perr; f0 = n_ferr;
    send_frame(8'h1C, 1'b1, 1'b1);
    checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL par_perr got=%0d exp=1", n_perr - p0); end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL par_ferr got=%0d exp=0", n_ferr - f0); end
    checks++; if (rx_q.size() - b !== 0) begin errors++; $display("FAIL par_rx got=%0d exp=0", rx_q.size() - b); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL par_count got=%0d exp=0", fifo_count); end
    b = rx_q.size(); p0 = n_perr; f0 = n_ferr;
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL stop_ferr got=%0d exp=1", n_ferr - f0); end
    checks++; if (n_perr - p0 !== 0) begin errors++; $display("FAIL stop_perr got=%0d exp=0", n_perr - p0); end
    checks++; if (rx_q.size() - b !== 0) begin errors++; $display("FAIL stop_rx got=%0d exp=0", rx_q.size() - b); end
  endtask

  task automatic test_overflow;
    int b, o0;
    logic [7:0] d;
    code_ready = 1'b0;
    b = rx_q.size(); o0 = n_ovf;
    for (int i = 0; i < 10; i++) begin
      d = 8'h10 + 8'(i);
      send_frame(d, 1'b0, 1'b1);
    end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
    checks++; if (n_ovf - o0 !== 2) begin errors++; $display("FAIL ovf_pulses got=%0d exp=2", n_ovf - o0); end
    checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%b exp=1", code_valid); end
    checks++; if (code_data !== CODE_W'(8'h10)) begin errors++; $display("FAIL ovf_head got=%h exp=10", code_data); end
    code_ready = 1'b1;
    tick(20);
    code_ready = 1'b0;
    checks++; if (rx_q.size() - b !== 8) begin errors++; $display("FAIL drain_cnt got=%0d exp=8", rx_q.size() - b); end
    else begin
      for (int i = 0; i < 8; i++) begin
        d = 8'h10 + 8'(i);
        checks++; if (rx_q[b+i] !== CODE_W'(d)) begin errors++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, rx_q[b+i], d); end
      end
    end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL drain_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_timeout;
    int b, f0;
    code_ready = 1'b1;
    b = rx_q.size(); f0 = n_ferr;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    ps2_data = 1'b1;
    tick(150);
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL timeout_ferr got=%0d exp=1", n_ferr - f0); end
    send_frame(8'h29, 1'b0, 1'b1);
    checks++; if (rx_q.size() - b !== 1) begin errors++; $display("FAIL after_to_cnt got=%0d exp=1", rx_q.size() - b); end
    else begin
      checks++; if (rx_q[b] !== CODE_W'(8'h29)) begin errors++; $display("FAIL after_to_data got=%h exp=29", rx_q[b]); end
    end
    checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL after_to_ferr got=%0d exp=1", n_ferr - f0); end
  endtask

  task automatic test_prefix;
    int b;
    code_ready = 1'b0;
    b = rx_q.size();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
`ifdef PS2_EXT_CODE_EN
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL pfx_count got=%0d exp=1", fifo_count); end
    checks++; if (code_data !== 10'h375) begin errors++; $display("FAIL pfx_head got=%h exp=375", code_data); end
`else
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL pfx_count got=%0d exp=3", fifo_count); end
    checks++; if (code_data !== CODE_W'(8'hE0)) begin errors++; $display("FAIL pfx_head got=%h exp=e0", code_data); end
`endif
    code_ready = 1'b1;
    tick(10);
    code_ready = 1'b0;
`ifdef PS2_EXT_CODE_EN
    checks++; if (rx_q.size() - b !== 1) begin errors++; $display("FAIL pfx_drain_cnt got=%0d exp=1", rx_q.size() - b); end
`else
    checks++; if (rx_q.size() - b !== 3) begin errors++; $display("FAIL pfx_drain_cnt got=%0d exp=3", rx_q.size() - b); end
    else begin
      checks++; if (rx_q[b+1] !== CODE_W'(8'hF0)) begin errors++; $display("FAIL pfx_second got=%h exp=f0", rx_q[b+1]); end
      checks++; if (rx_q[b+2] !== CODE_W'(8'h75)) begin errors++; $display("FAIL pfx_third got=%h exp=75", rx_q[b+2]); end
    end
`endif
  endtask

  task automatic test_reset_mid;
    int b, f0, p0;
    code_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    send_frame(8'h33, 1'b0, 1'b1);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL mid_pre_count got=%0d exp=3", fifo_count); end
    f0 = n_ferr; p0 = n_perr;
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    tick(5);
    rst = 1'b1;
    #1;
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", code_valid); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
    checks++; if (code_data !== '0) begin errors++; $display("FAIL mid_data got=%h exp=0", code_data); end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(20);
    code_ready = 1'b1;
    b = rx_q.size();
    send_frame(8'h5A, 1'b0, 1'b1);
    checks++; if (rx_q.size() - b !== 1) begin errors++; $display("FAIL mid_after_cnt got=%0d exp=1", rx_q.size() - b); end
    else begin
      checks++; if (rx_q[b] !== CODE_W'(8'h5A)) begin errors++; $display("FAIL mid_after_data got=%h exp=5a", rx_q[b]); end
    end
    checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL mid_ferr got=%0d exp=0", n_ferr - f0); end
    checks++; if (n_perr - p0 !== 0) begin errors++; $display("FAIL mid_perr got=%0d exp=0", n_perr - p0); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_errors;
    test_overflow;
    test_timeout;
    test_prefix;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
